// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller:
// scan FSM encoding, active-low blanking constants and the hex glyph table.
package seg7_pkg;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational nibble-to-glyph lookup; holds no state.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed 4-digit display scanner with a double-buffered digit store.
// New digits only reach the display at a frame boundary, so a frame never tears.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    output logic       commit_pending,
    output logic       frame_done,
    output logic [3:0] an,
    output logic [6:0] seg7
);

    localparam int SHOW_CYCLES = PRESCALE - BLANK_CYCLES;
    localparam int CW          = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [0:0]    state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [3:0]    shadow      [4];
    logic [3:0]    shadow_next [4];
    logic [3:0]    active      [4];
    logic [6:0]    glyph;
    logic          last_blank;
    logic          last_show;
    logic          do_copy;

    assign last_blank = (cnt == CW'(BLANK_CYCLES - 1));
    assign last_show  = (cnt == CW'(SHOW_CYCLES - 1));
    assign frame_done = (state == ST_SHOW) && (idx == 2'd3) && last_show;
    assign do_copy    = frame_done && (commit_pending || commit);

    // A write landing on the frame boundary must be part of the copy.
    always_comb begin
        shadow_next = shadow;
        if (wr_en) begin
            shadow_next[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            idx   <= 2'd0;
            cnt   <= '0;
        end else if (state == ST_BLANK) begin
            if (last_blank) begin
                state <= ST_SHOW;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            if (last_show) begin
                state <= ST_BLANK;
                idx   <= idx + 2'd1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
            commit_pending <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if (do_copy) begin
                active         <= shadow_next;
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    hex_to_seg7 u_decode (
        .nibble (active[idx]),
        .seg    (glyph)
    );

    // Outputs trail the scan state by one cycle and carry no input paths.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an   <= ANODES_OFF;
            seg7 <= SEG_OFF;
        end else if (state == ST_SHOW) begin
            an   <= anode_for(idx);
            seg7 <= glyph;
        end else begin
            an   <= ANODES_OFF;
            seg7 <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller at PRESCALE=8, BLANK_CYCLES=2,
// with a background monitor for scan timing and anode exclusivity.
module tb_seg7_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic       frame_done;
    logic [3:0] an;
    logic [6:0] seg7;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .an             (an),
        .seg7           (seg7)
    );

    // Background timing monitor, restarted around every reset.
    logic last_rst    = 1'b0;
    int   blank_run   = 0;
    int   since_frame = 0;
    bit   have_frame  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n || !last_rst) begin
            blank_run   = 0;
            since_frame = 0;
            have_frame  = 1'b0;
        end else begin
            checks++;
            if (!(an === 4'b1111 || $countones(an) == 3)) begin
                errors++;
                $display("[TB] FAIL anode_onehot: an=%b required all-off or one low", an);
            end
            if (an === 4'b1111) begin
                blank_run++;
                checks++;
                if (seg7 !== 7'b1111111) begin
                    errors++;
                    $display("[TB] FAIL blank_seg: seg7=%b required 1111111", seg7);
                end
            end else begin
                if (blank_run != 0) begin
                    checks++;
                    if (blank_run !== 2) begin
                        errors++;
                        $display("[TB] FAIL blank_count: got %0d all-off cycles required 2", blank_run);
                    end
                end
                blank_run = 0;
            end
            since_frame++;
            if (frame_done) begin
                if (have_frame) begin
                    checks++;
                    if (since_frame !== 32) begin
                        errors++;
                        $display("[TB] FAIL frame_period: got %0d cycles required 32", since_frame);
                    end
                end
                have_frame  = 1'b1;
                since_frame = 0;
            end
        end
        last_rst = rst_n;
    end

    task automatic pulse_write(input logic [1:0] addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
    endtask

    task automatic wait_frame_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL frame_timeout: frame_done=0 for 40 cycles required a pulse");
        end
    endtask

    // Entered on the frame_done negedge; samples the middle of each digit slot.
    task automatic read_digits(output logic [15:0] an_s, output logic [27:0] seg_s);
        an_s  = '0;
        seg_s = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n >= 6 && ((n - 6) % 8) == 0) begin
                an_s[4*((n-6)/8) +: 4]  = an;
                seg_s[7*((n-6)/8) +: 7] = seg7;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 4'h5;
        commit  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: an=%b required 1111", an); end
        checks++;
        if (seg7 !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_seg: seg7=%b required 1111111", seg7); end
        checks++;
        if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b required 0", commit_pending); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b required 0", frame_done); end
        rst_n  = 1'b1;
        wr_en  = 1'b0;
        commit = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1111 || seg7 !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL release_blank: an=%b seg7=%b required 1111/1111111", an, seg7);
        end
        checks++;
        if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_ignored: got %b required 0", commit_pending); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110 || seg7 !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL release_digit0: an=%b seg7=%b required 1110/1000000", an, seg7);
        end
    endtask

    task automatic test_update();
        logic [15:0] an_s, exp_an;
        logic [27:0] seg_s, exp_seg;
        exp_an  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        exp_seg = {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010};
        pulse_write(2'd0, 4'h6);
        pulse_write(2'd1, 4'h7);
        pulse_write(2'd2, 4'h8);
        pulse_write(2'd3, 4'h9);
        pulse_commit();
        checks++;
        if (commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL update_pending_set: got %b required 1", commit_pending); end
        wait_frame_done();
        checks++;
        if (commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL update_pending_held: got %b required 1", commit_pending); end
        read_digits(an_s, seg_s);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (an_s[4*k +: 4] !== exp_an[4*k +: 4] || seg_s[7*k +: 7] !== exp_seg[7*k +: 7]) begin
                errors++;
                $display("[TB] FAIL update_digit%0d: an=%b seg7=%b required %b/%b",
                         k, an_s[4*k +: 4], seg_s[7*k +: 7], exp_an[4*k +: 4], exp_seg[7*k +: 7]);
            end
        end
        checks++;
        if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL update_pending_clear: got %b required 0", commit_pending); end
    endtask

    task automatic test_no_tear();
        logic [15:0] an_s;
        logic [27:0] seg_s;
        wait_frame_done();
        repeat (12) @(posedge clk);
        #1;
        pulse_write(2'd0, 4'hF);
        for (int f = 0; f < 2; f++) begin
            wait_frame_done();
            read_digits(an_s, seg_s);
            checks++;
            if (an_s[3:0] !== 4'b1110 || seg_s[6:0] !== 7'b0000010) begin
                errors++;
                $display("[TB] FAIL no_tear_frame%0d: an=%b seg7=%b required 1110/0000010", f, an_s[3:0], seg_s[6:0]);
            end
        end
        checks++;
        if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL no_tear_pending: got %b required 0", commit_pending); end
    endtask

    // Write and commit land on the frame_done cycle itself.
    task automatic test_back_to_back();
        logic [15:0] an_s, exp_an;
        logic [27:0] seg_s, exp_seg;
        exp_an  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        exp_seg = {7'b0010000, 7'b0001000, 7'b1111000, 7'b0001110};
        repeat (2) @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 4'hA;
        commit  = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_on_boundary: frame_done=%b required 1", frame_done); end
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
        checks++;
        if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pending: got %b required 0", commit_pending); end
        read_digits(an_s, seg_s);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (an_s[4*k +: 4] !== exp_an[4*k +: 4] || seg_s[7*k +: 7] !== exp_seg[7*k +: 7]) begin
                errors++;
                $display("[TB] FAIL b2b_digit%0d: an=%b seg7=%b required %b/%b",
                         k, an_s[4*k +: 4], seg_s[7*k +: 7], exp_an[4*k +: 4], exp_seg[7*k +: 7]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] an_s, exp_an;
        logic [27:0] seg_s;
        exp_an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        repeat (10) @(posedge clk);
        #1;
        pulse_commit();
        checks++;
        if (commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending_set: got %b required 1", commit_pending); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (commit_pending !== 1'b0 || an !== 4'b1111 || seg7 !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: pending=%b an=%b seg7=%b required 0/1111/1111111", commit_pending, an, seg7);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110 || seg7 !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL mid_restart: an=%b seg7=%b required 1110/1000000", an, seg7);
        end
        wait_frame_done();
        read_digits(an_s, seg_s);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (an_s[4*k +: 4] !== exp_an[4*k +: 4] || seg_s[7*k +: 7] !== 7'b1000000) begin
                errors++;
                $display("[TB] FAIL mid_digit%0d: an=%b seg7=%b required %b/1000000",
                         k, an_s[4*k +: 4], seg_s[7*k +: 7], exp_an[4*k +: 4]);
            end
        end
        checks++;
        if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL mid_pending_after: got %b required 0", commit_pending); end
    endtask

    initial begin
        test_reset();
        test_update();
        test_no_tear();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg7_scan_controller.md
SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: clock cycles per digit slot, including the blank cycles.
REQ-002 SHALL have parameter BLANK_CYCLES, default 4: anode-off dead time at the start of each slot; BLANK_CYCLES < PRESCALE.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1 bit: write strobe into the shadow digit buffer.
REQ-006 SHALL have port wr_addr, input, 2 bits: digit index to write; 0 is the rightmost digit, driven by an[0].
REQ-007 SHALL have port wr_data, input, 4 bits: hex/BCD nibble.
REQ-008 SHALL have port commit, input, 1 bit: request to copy the shadow buffer to the active buffer at the next frame boundary.
REQ-009 SHALL have port commit_pending, output, 1 bit: a commit is requested but not yet applied.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of digit 3's slot.
REQ-011 SHALL have port an, output, 4 bits: digit anodes, active-low.
REQ-012 SHALL have port seg7, output, 7 bits: {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 SHALL write wr_data to shadow[wr_addr] on any cycle with wr_en=1; the write is visible in shadow on the next cycle.
REQ-014 SHALL use a scan FSM with two states:
- BLANK: an=4'b1111, seg7=7'b1111111; lasts BLANK_CYCLES cycles; then go to SHOW.
- SHOW: an has only bit idx low; seg7=decode(active[idx]); lasts PRESCALE-BLANK_CYCLES cycles; then idx<=idx+1 (3 wraps to 0) and go to BLANK.
REQ-015 SHALL give each digit exactly PRESCALE cycles per slot, so one frame is 4*PRESCALE cycles.
REQ-016 SHALL assert frame_done for exactly the last SHOW cycle of idx=3.
REQ-017 SHALL set commit_pending on the cycle after commit=1; commit while already pending has no further effect.
REQ-018 SHALL, on the frame_done cycle, when commit_pending=1 or commit=1: copy shadow to active (all four digits atomically) and clear commit_pending on the next cycle.
REQ-019 SHALL include in the copy a wr_en write that occurs on the frame_done cycle itself (write-through into the copy); last write wins.
REQ-020 SHALL never change active outside a frame_done cycle; the display never tears mid-frame.
REQ-021 SHALL decode nibbles 0-F as hexadecimal glyphs: 0=1000000, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, F=0001110.
REQ-022 SHALL register an and seg7 (no combinational path from inputs), with one cycle latency from an FSM state change.
REQ-023 SHALL bound commit-to-display latency at ≤ 4*PRESCALE+1 cycles.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, set: state=BLANK, idx=0, prescale counter=0, shadow=active=0, commit_pending=0, frame_done=0, an=4'b1111, seg7=7'b1111111.
REQ-025 SHALL discard a pending commit on reset mid-frame; the first post-reset slot is BLANK of digit 0.
REQ-026 SHALL ignore wr_en and commit during reset.

Structure
REQ-027 SHALL place the FSM state encoding, the active-low ANODES_OFF and SEG_OFF constants, and the glyph table in a shared package seg7_pkg.
REQ-028 SHALL implement the decoder as a combinational sub-module hex_to_seg7 (4-bit in, 7-bit out); all registers stay in seg7_scan_controller.

Verification
REQ-029 SHALL run all scenarios with PRESCALE=8, BLANK_CYCLES=2.
REQ-030 SHALL cover reset: hold rst_n=0 for 3 cycles, release -> an=1111, seg7=1111111; 2 cycles later an=1110, seg7=1000000.
REQ-031 SHALL cover the update: write 6,7,8,9 to addr 0..3, pulse commit -> commit_pending=1; after the next frame_done, the slot sequence shows an=1110/0000010, 1101/1111000, 1011/0000000, 0111/0010000, and commit_pending=0.
REQ-032 SHALL cover no-tear: commit active, write addr0=F mid-frame without commit -> displayed digit 0 is unchanged for ≥2 frames.
REQ-033 SHALL cover the simultaneous event: wr_en (addr2=A) plus commit on the frame_done cycle -> the next frame shows 0001000 on an=1011.
REQ-034 SHALL cover reset mid-operation: commit pending, rst_n=0 for 1 cycle mid-frame -> commit_pending=0, all digits show 0, scan restarts at digit 0.
REQ-035 SHALL check timing throughout: frame_done period = 32 cycles; an never has more than one bit low; exactly 2 all-off cycles precede every digit.
